// File: rtl/taillight_sequencer_if.sv
// Switch and lamp-bank bundle for the taillight sequencer.
//   master : drives step_clock, left_turn, right_turn, hazard, brake;
//            receives left_lights / right_lights.
//   slave  : the sequencer; receives the switches and the divided clock,
//            drives both lamp banks (LAMPS wide, bit 0 innermost).
interface taillight_sequencer_if #(
    parameter int LAMPS = 3
);
    logic             step_clock;
    logic             left_turn;
    logic             right_turn;
    logic             hazard;
    logic             brake;
    logic [LAMPS-1:0] left_lights;
    logic [LAMPS-1:0] right_lights;

    modport master (
        output step_clock, left_turn, right_turn, hazard, brake,
        input  left_lights, right_lights
    );

    modport slave (
        input  step_clock, left_turn, right_turn, hazard, brake,
        output left_lights, right_lights
    );
endinterface

// File: rtl/taillight_sequencer.sv
// Thunderbird-style taillight sequencer.
// Runs on the fast board clock, synchronizes the divided step clock and the
// switches, and advances the lamp pattern once per step_clock rising edge.
// Ports:
//   in_clock : fast board clock (single domain)
//   reset    : synchronous, active-high
//   bus      : slave side of taillight_sequencer_if
//              (step_clock, left_turn, right_turn, hazard, brake in;
//               left_lights, right_lights out, registered)
module taillight_sequencer #(
    parameter int LAMPS       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  in_clock,
    input  logic                  reset,
    taillight_sequencer_if.slave  bus
);
    localparam int PW    = $clog2(LAMPS + 1);
    localparam int NSYNC = 5;
    localparam logic [PW-1:0] POS_MAX = PW'(LAMPS);
    localparam logic [PW-1:0] POS_ONE = PW'(1);
    localparam logic [PW-1:0] POS_ZERO = {PW{1'b0}};

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_LEFT  = 2'd1,
        MODE_RIGHT = 2'd2,
        MODE_HAZ   = 2'd3
    } mode_e;

    // Synchronizer bit positions inside each stage vector.
    localparam int B_STEP  = 0;
    localparam int B_LEFT  = 1;
    localparam int B_RIGHT = 2;
    localparam int B_HAZ   = 3;
    localparam int B_BRAKE = 4;

    logic [NSYNC-1:0] raw_s;
    logic [NSYNC-1:0] synced_s;
    logic [NSYNC-1:0] sync_d [SYNC_STAGES];
    logic [NSYNC-1:0] sync_q [SYNC_STAGES];
    logic             edge_d;
    logic             edge_q;
    logic             step_s;
    mode_e            req_s;
    mode_e            mode_d;
    mode_e            mode_q;
    logic [PW-1:0]    pos_d;
    logic [PW-1:0]    pos_q;
    logic [LAMPS-1:0] left_d;
    logic [LAMPS-1:0] left_q;
    logic [LAMPS-1:0] right_d;
    logic [LAMPS-1:0] right_q;
    logic [LAMPS-1:0] brake_all_s;

    // Lowest k bits set.
    function automatic logic [LAMPS-1:0] therm(input logic [PW-1:0] k);
        logic [LAMPS-1:0] t;
        t = {LAMPS{1'b0}};
        for (int i = 0; i < LAMPS; i++) begin
            if (PW'(i) < k) begin
                t[i] = 1'b1;
            end else begin
                t[i] = 1'b0;
            end
        end
        return t;
    endfunction

    assign raw_s = {bus.brake, bus.hazard, bus.right_turn, bus.left_turn, bus.step_clock};
    assign synced_s = sync_q[SYNC_STAGES-1];
    // One-cycle pulse on each synchronized rising edge of step_clock.
    assign step_s = synced_s[B_STEP] & ~edge_q;
    assign edge_d = synced_s[B_STEP];
    assign brake_all_s = {LAMPS{synced_s[B_BRAKE]}};

    // Synchronizer chain: stage 0 samples the raw inputs, later stages shift.
    always_comb begin
        sync_d[0] = raw_s;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Request priority: hazard (or both turns) over left over right.
    always_comb begin
        req_s = MODE_IDLE;
        if (synced_s[B_HAZ] || (synced_s[B_LEFT] && synced_s[B_RIGHT])) begin
            req_s = MODE_HAZ;
        end else if (synced_s[B_LEFT]) begin
            req_s = MODE_LEFT;
        end else if (synced_s[B_RIGHT]) begin
            req_s = MODE_RIGHT;
        end else begin
            req_s = MODE_IDLE;
        end
    end

    // Mode/position next state; only a step cycle may change anything.
    always_comb begin
        mode_d = mode_q;
        pos_d  = pos_q;
        if (step_s) begin
            if (req_s != mode_q) begin
                // A new request always restarts its pattern at the first lamp.
                mode_d = req_s;
                if (req_s == MODE_IDLE) begin
                    pos_d = POS_ZERO;
                end else begin
                    pos_d = POS_ONE;
                end
            end else begin
                case (mode_q)
                    MODE_LEFT, MODE_RIGHT: begin
                        if (pos_q == POS_MAX) begin
                            pos_d = POS_ZERO;
                        end else begin
                            pos_d = pos_q + POS_ONE;
                        end
                    end
                    MODE_HAZ: pos_d = pos_q ^ POS_ONE;
                    default:  pos_d = POS_ZERO;
                endcase
            end
        end else begin
            mode_d = mode_q;
            pos_d  = pos_q;
        end
    end

    // Lamp decode from next state so the lamps change with the step itself.
    always_comb begin
        left_d  = brake_all_s;
        right_d = brake_all_s;
        case (mode_d)
            MODE_LEFT: begin
                left_d  = therm(pos_d);
                right_d = brake_all_s;
            end
            MODE_RIGHT: begin
                left_d  = brake_all_s;
                right_d = therm(pos_d);
            end
            MODE_HAZ: begin
                left_d  = {LAMPS{pos_d[0]}};
                right_d = {LAMPS{pos_d[0]}};
            end
            default: begin
                left_d  = brake_all_s;
                right_d = brake_all_s;
            end
        endcase
    end

    // All state; synchronizers and edge flop preset high so a step_clock
    // already high at reset release is not seen as a rising edge.
    always_ff @(posedge in_clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= {NSYNC{1'b1}};
            end
            edge_q  <= 1'b1;
            mode_q  <= MODE_IDLE;
            pos_q   <= POS_ZERO;
            left_q  <= {LAMPS{1'b0}};
            right_q <= {LAMPS{1'b0}};
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            edge_q  <= edge_d;
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            left_q  <= left_d;
            right_q <= right_d;
        end
    end

    assign bus.left_lights  = left_q;
    assign bus.right_lights = right_q;
endmodule

// File: tb/tb_taillight_sequencer.sv
module tb_taillight_sequencer;
    localparam int L = 3;
    localparam logic [L-1:0] ALL = 3'b111;

    // Reference model modes
    localparam int R_NONE = 0;
    localparam int R_LEFT = 1;
    localparam int R_RIGHT = 2;
    localparam int R_HAZ = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_mode = R_NONE;
    int   m_pos = 0;

    taillight_sequencer_if #(.LAMPS(L)) bus();

    taillight_sequencer #(.LAMPS(L), .SYNC_STAGES(2)) dut (
        .in_clock(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected banks from the model state and the (settled) brake level.
    function automatic logic [L-1:0] exp_left(input logic brk);
        if (m_mode == R_LEFT) return L'((1 << m_pos) - 1);
        if (m_mode == R_HAZ) return (m_pos % 2 == 1) ? ALL : '0;
        return brk ? ALL : '0;
    endfunction

    function automatic logic [L-1:0] exp_right(input logic brk);
        if (m_mode == R_RIGHT) return L'((1 << m_pos) - 1);
        if (m_mode == R_HAZ) return (m_pos % 2 == 1) ? ALL : '0;
        return brk ? ALL : '0;
    endfunction

    task automatic model_step();
        int req;
        if (bus.hazard || (bus.left_turn && bus.right_turn)) req = R_HAZ;
        else if (bus.left_turn) req = R_LEFT;
        else if (bus.right_turn) req = R_RIGHT;
        else req = R_NONE;
        if (req != m_mode) begin
            m_mode = req;
            m_pos = (req == R_NONE) ? 0 : 1;
        end else if (req == R_LEFT || req == R_RIGHT) begin
            m_pos = (m_pos + 1) % (L + 1);
        end else if (req == R_HAZ) begin
            m_pos = 1 - m_pos;
        end
    endtask

    task automatic set_sw(input logic l, input logic r, input logic h, input logic b);
        @(negedge clk);
        bus.left_turn = l;
        bus.right_turn = r;
        bus.hazard = h;
        bus.brake = b;
        repeat (4) @(negedge clk);
    endtask

    // One step_clock pulse: lamps must still hold after the 2nd edge and
    // show the new pattern after the 3rd edge.
    task automatic step_once(input string tag);
        logic [L-1:0] pl, pr, el, er;
        pl = exp_left(bus.brake);
        pr = exp_right(bus.brake);
        model_step();
        el = exp_left(bus.brake);
        er = exp_right(bus.brake);
        @(negedge clk);
        bus.step_clock = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.left_lights !== pl || bus.right_lights !== pr) begin
            n_fail++;
            $display("FAIL %s early: got %b/%b want %b/%b", tag,
                     bus.left_lights, bus.right_lights, pl, pr);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.left_lights !== el || bus.right_lights !== er) begin
            n_fail++;
            $display("FAIL %s: got %b/%b want %b/%b", tag,
                     bus.left_lights, bus.right_lights, el, er);
        end
        repeat (2) @(negedge clk);
        bus.step_clock = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic check_steady(input string tag);
        n_checks++;
        if (bus.left_lights !== exp_left(bus.brake) || bus.right_lights !== exp_right(bus.brake)) begin
            n_fail++;
            $display("FAIL %s: got %b/%b want %b/%b", tag, bus.left_lights,
                     bus.right_lights, exp_left(bus.brake), exp_right(bus.brake));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.step_clock = 1'b0;
        bus.left_turn = 1'b0;
        bus.right_turn = 1'b0;
        bus.hazard = 1'b0;
        bus.brake = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.left_lights !== 3'b000 || bus.right_lights !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_value: got %b/%b want 000/000", bus.left_lights, bus.right_lights);
        end
        @(negedge clk);
        reset = 1'b0;
        m_mode = R_NONE;
        m_pos = 0;
        repeat (6) @(negedge clk);
        check_steady("reset_idle");
    endtask

    task automatic test_left_sequence();
        set_sw(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step_once("left_seq");
    endtask

    task automatic test_right_with_brake();
        set_sw(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step_once("right_brake");
    endtask

    task automatic test_hazard();
        set_sw(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step_once("hazard");
        set_sw(1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step_once("hazard_both_turns");
    endtask

    task automatic test_reversal();
        set_sw(1'b1, 1'b0, 1'b0, 1'b0);
        step_once("rev_setup");
        step_once("rev_setup");
        set_sw(1'b0, 1'b1, 1'b0, 1'b0);
        step_once("reversal");
        set_sw(1'b0, 1'b0, 1'b0, 1'b0);
        step_once("release_to_idle");
    endtask

    task automatic test_brake_latency();
        @(negedge clk);
        bus.brake = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.left_lights !== 3'b000 || bus.right_lights !== 3'b000) begin
            n_fail++;
            $display("FAIL brake_early: got %b/%b want 000/000", bus.left_lights, bus.right_lights);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.left_lights !== ALL || bus.right_lights !== ALL) begin
            n_fail++;
            $display("FAIL brake_on: got %b/%b want 111/111", bus.left_lights, bus.right_lights);
        end
        set_sw(1'b0, 1'b0, 1'b0, 1'b0);
        check_steady("brake_off");
    endtask

    task automatic test_long_step_high();
        logic [L-1:0] el;
        set_sw(1'b1, 1'b0, 1'b0, 1'b0);
        model_step();
        el = exp_left(1'b0);
        @(negedge clk);
        bus.step_clock = 1'b1;
        repeat (50) @(negedge clk);
        n_checks++;
        if (bus.left_lights !== el) begin
            n_fail++;
            $display("FAIL long_high: got %b want %b", bus.left_lights, el);
        end
        bus.step_clock = 1'b0;
        repeat (5) @(negedge clk);
        check_steady("long_high_after");
    endtask

    task automatic test_reset_step_high();
        @(negedge clk);
        reset = 1'b1;
        bus.step_clock = 1'b1;
        bus.left_turn = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_mode = R_NONE;
        m_pos = 0;
        repeat (10) @(negedge clk);
        check_steady("reset_step_high");
        bus.step_clock = 1'b0;
        repeat (4) @(negedge clk);
        check_steady("reset_step_high_low");
        step_once("first_after_reset_high");
    endtask

    task automatic test_reset_mid_sequence();
        set_sw(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5 && !(m_mode == R_LEFT && m_pos == 3); i++)
            step_once("mid_setup");
        @(negedge clk);
        bus.step_clock = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.left_lights !== 3'b000 || bus.right_lights !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid: got %b/%b want 000/000", bus.left_lights, bus.right_lights);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.step_clock = 1'b0;
        m_mode = R_NONE;
        m_pos = 0;
        repeat (6) @(negedge clk);
        check_steady("reset_mid_idle");
        step_once("reset_mid_restart");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [3:0] sw;
            sw = 4'($urandom_range(0, 15));
            if (sw[2] && ($urandom_range(0, 1) == 0)) sw[2] = 1'b0;
            set_sw(sw[0], sw[1], sw[2], sw[3]);
            check_steady("rand_settle");
            repeat ($urandom_range(1, 3)) begin
                repeat ($urandom_range(0, 4)) @(negedge clk);
                step_once("rand_step");
            end
        end
    endtask

    initial begin
        test_reset();
        test_left_sequence();
        test_right_with_brake();
        test_hazard();
        test_reversal();
        test_brake_latency();
        test_long_step_high();
        test_reset_step_high();
        test_reset_mid_sequence();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
